phaser_lock_sequencer: RTL and testbench
========================================

Name: phaser_lock_sequencer

Overview:
- Sits directly downstream of the phaser reference stage and consumes its LOCKED output. It also drives that stage's RST and PWRDWN inputs.
- Synchronises LOCKED, checks that the lock stays stable, and releases the PHY-side reset (PHASER_IN/OUT, IO logic) only after a settle delay.
- Retries with a fresh phaser reset pulse on lock timeout. Reports lock loss, timeout and relock count to the calibration/status logic.

Parameters:
- SYNC_STAGES, 2, flops in the locked_i synchroniser (legal 2..4)
- RST_PULSE_CYCLES, 8, width of the phaser_rst_o pulse per attempt (>=1)
- STABLE_CYCLES, 64, consecutive synchronised-high cycles required before lock is accepted (>=1)
- RELEASE_CYCLES, 16, cycles from accepted lock to phy_rst_o deassert (>=1)
- TIMEOUT_CYCLES, 4096, max cycles in WAIT_LOCK before a retry (>=2)
- CNT_W, 8, width of relock_cnt_o

Ports:
- delay_CLKIN  in  1  reference clock; all state clocked on its rising edge
- delay_RST  in  1  reset, asynchronous, active-high
- locked_i  in  1  LOCKED from phaser reference stage, asynchronous to delay_CLKIN
- pwrdwn_i  in  1  power-down request, synchronous, level
- phaser_rst_o  out  1  to phaser reference RST, active-high
- phaser_pwrdwn_o  out  1  to phaser reference PWRDWN, active-high
- phy_rst_o  out  1  reset to downstream PHY logic, active-high
- ready_o  out  1  lock accepted and PHY out of reset
- lock_lost_o  out  1  one-cycle pulse when lock drops while in READY
- timeout_o  out  1  sticky; set on first WAIT_LOCK timeout
- relock_cnt_o  out  CNT_W  count of READY->lock-loss events, saturating at all ones
- state_o  out  3  encoded FSM state, for debug

Behaviour:
- Reset (delay_RST high, async) sets:
  - phaser_rst_o=1, phaser_pwrdwn_o=0, phy_rst_o=1, ready_o=0, lock_lost_o=0, timeout_o=0, relock_cnt_o=0
  - synchroniser flops=0, all counters=0, state=PRST
- Deassertion of delay_RST is used directly. An external reset bridge guarantees a synchronous release.
- lk_s is locked_i after SYNC_STAGES flops. All decisions use lk_s only, which adds SYNC_STAGES cycles of latency.
- State encoding: PRST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, READY=4, PDOWN=5.
- Single counter cnt, cleared on every state transition.
- PRST:
  - phaser_rst_o=1, phy_rst_o=1.
  - After RST_PULSE_CYCLES cycles (cnt==RST_PULSE_CYCLES-1), go to WAIT_LOCK.
- WAIT_LOCK:
  - phaser_rst_o=0, phy_rst_o=1.
  - lk_s=1 -> STABLE.
  - Otherwise, at cnt==TIMEOUT_CYCLES-1 set timeout_o and go to PRST (retry).
- STABLE:
  - lk_s=0 -> WAIT_LOCK (no timeout carry-over; cnt restarts).
  - At cnt==STABLE_CYCLES-1 with lk_s=1 -> RELEASE.
- RELEASE:
  - lk_s=0 -> WAIT_LOCK.
  - At cnt==RELEASE_CYCLES-1 -> READY. phy_rst_o deasserts on the same edge that enters READY.
- READY:
  - phy_rst_o=0, ready_o=1.
  - lk_s=0 -> WAIT_LOCK. On that edge: phy_rst_o=1, ready_o=0, lock_lost_o pulses for exactly one cycle, relock_cnt_o increments (saturating).
- PDOWN:
  - phaser_pwrdwn_o=1, phaser_rst_o=1, phy_rst_o=1, ready_o=0.
  - pwrdwn_i=0 -> PRST.
- pwrdwn_i=1 has priority over every other transition from every state: next state is PDOWN. If lock is lost in that same cycle from READY, lock_lost_o still pulses and the count still increments.
- All outputs are registered (Moore); no combinational path from input to output.
- Latency: locked_i rising (stable) to ready_o=1 is SYNC_STAGES+STABLE_CYCLES+RELEASE_CYCLES+1 cycles, ±1 for synchroniser metastability.
- timeout_o clears only on delay_RST.
- Glitch on locked_i shorter than one clock may be missed or caught; either outcome is legal.
- Counter width is clog2 of the largest of the cycle parameters.

Decomposition:
- Shared package phaser_pkg holds:
  - state enum phaser_seq_state_t with the encodings above
  - default parameter constants
  - a clog2 helper
- One sub-module: phaser_sync_bit, an N-stage async-input synchroniser with async reset to 0. It is reused by the phaser_in/phaser_out control blocks.

Test Plan:
- Reset release, locked_i held 0, TIMEOUT_CYCLES=64 -> phaser_rst_o high 8 cycles; after 64 WAIT_LOCK cycles timeout_o=1, state returns to PRST, phaser_rst_o pulses again.
- locked_i rises 20 cycles after PRST and stays high (defaults) -> ready_o=1 and phy_rst_o=0 exactly 2+64+16+1=83 cycles later (±1).
- locked_i drops for 5 cycles at STABLE cnt=30 -> return to WAIT_LOCK; ready_o only after a full fresh 64+16 window; relock_cnt_o stays 0.
- In READY, drop locked_i -> lock_lost_o one-cycle pulse, phy_rst_o=1 and relock_cnt_o=1 within SYNC_STAGES+1 cycles. With CNT_W=2 and 5 losses -> relock_cnt_o=3.
- pwrdwn_i=1 in RELEASE -> next cycle state_o=5, phaser_pwrdwn_o=1, phaser_rst_o=1. Then pwrdwn_i=0 -> PRST, full resequence.
- delay_RST asserted asynchronously mid-READY -> all outputs take reset values immediately without a clock edge; timeout_o and relock_cnt_o = 0.

Source files
------------

// File: rtl/phaser_pkg.sv
// Shared types and defaults for the phaser reference lock sequencer and its helpers.
package phaser_pkg;

  typedef enum logic [2:0] {
    StPrst     = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRelease  = 3'd3,
    StReady    = 3'd4,
    StPdown    = 3'd5
  } phaser_seq_state_t;

  localparam int unsigned SyncStagesDef    = 2;
  localparam int unsigned RstPulseDef      = 8;
  localparam int unsigned StableCyclesDef  = 64;
  localparam int unsigned ReleaseCyclesDef = 16;
  localparam int unsigned TimeoutDef       = 4096;
  localparam int unsigned CntWDef          = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/phaser_sync_bit.sv
// N-stage synchroniser for a single asynchronous level, flops reset to 0.
module phaser_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/phaser_lock_sequencer.sv
// Resets the phaser reference, waits for a stable LOCKED, then releases the PHY reset.
// Retries on lock timeout and reports lock loss / relock count.
module phaser_lock_sequencer
  import phaser_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SyncStagesDef,
  parameter int unsigned RST_PULSE_CYCLES = RstPulseDef,
  parameter int unsigned STABLE_CYCLES  = StableCyclesDef,
  parameter int unsigned RELEASE_CYCLES = ReleaseCyclesDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDef,
  parameter int unsigned CNT_W          = CntWDef
) (
  input  logic             delay_CLKIN,
  input  logic             delay_RST,
  input  logic             locked_i,
  input  logic             pwrdwn_i,
  output logic             phaser_rst_o,
  output logic             phaser_pwrdwn_o,
  output logic             phy_rst_o,
  output logic             ready_o,
  output logic             lock_lost_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] relock_cnt_o,
  output logic [2:0]       state_o
);

  localparam int unsigned MaxA   = (RST_PULSE_CYCLES > STABLE_CYCLES) ?
                                   RST_PULSE_CYCLES : STABLE_CYCLES;
  localparam int unsigned MaxB   = (RELEASE_CYCLES > TIMEOUT_CYCLES) ?
                                   RELEASE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = (clog2(MaxCyc) < 1) ? 1 : clog2(MaxCyc);

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] ReleaseLast = CntW'(RELEASE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  logic              w_lk_s;
  phaser_seq_state_t w_state_d;
  logic              w_lost;
  logic              w_timeout;

  phaser_seq_state_t r_state;
  logic [CntW-1:0]   r_cnt;
  logic              r_phaser_rst;
  logic              r_phaser_pwrdwn;
  logic              r_phy_rst;
  logic              r_ready;
  logic              r_lock_lost;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_relock_cnt;

  phaser_sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk(delay_CLKIN),
    .i_rst(delay_RST),
    .i_d  (locked_i),
    .o_q  (w_lk_s)
  );

  always_comb begin
    w_state_d = r_state;
    w_lost    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      StPrst: begin
        if (r_cnt == RstLast) w_state_d = StWaitLock;
      end
      StWaitLock: begin
        if (w_lk_s) begin
          w_state_d = StStable;
        end else if (r_cnt == TimeoutLast) begin
          w_state_d = StPrst;
          w_timeout = 1'b1;
        end
      end
      StStable: begin
        if (!w_lk_s)                   w_state_d = StWaitLock;
        else if (r_cnt == StableLast)  w_state_d = StRelease;
      end
      StRelease: begin
        if (!w_lk_s)                   w_state_d = StWaitLock;
        else if (r_cnt == ReleaseLast) w_state_d = StReady;
      end
      StReady: begin
        if (!w_lk_s) begin
          w_state_d = StWaitLock;
          w_lost    = 1'b1;
        end
      end
      StPdown: begin
        if (!pwrdwn_i) w_state_d = StPrst;
      end
      default: w_state_d = StPrst;
    endcase
    // Power-down overrides every transition, but a concurrent lock loss is still reported.
    if (pwrdwn_i) begin
      w_state_d = StPdown;
      w_timeout = 1'b0;
    end
  end

  always_ff @(posedge delay_CLKIN or posedge delay_RST) begin
    if (delay_RST) begin
      r_state         <= StPrst;
      r_cnt           <= '0;
      r_phaser_rst    <= 1'b1;
      r_phaser_pwrdwn <= 1'b0;
      r_phy_rst       <= 1'b1;
      r_ready         <= 1'b0;
      r_lock_lost     <= 1'b0;
      r_timeout       <= 1'b0;
      r_relock_cnt    <= '0;
    end else begin
      r_state         <= w_state_d;
      r_cnt           <= (w_state_d != r_state) ? '0 : r_cnt + 1'b1;
      r_phaser_rst    <= (w_state_d == StPrst) || (w_state_d == StPdown);
      r_phaser_pwrdwn <= (w_state_d == StPdown);
      r_phy_rst       <= (w_state_d != StReady);
      r_ready         <= (w_state_d == StReady);
      r_lock_lost     <= w_lost;
      if (w_timeout) r_timeout <= 1'b1;
      if (w_lost && (r_relock_cnt != {CNT_W{1'b1}})) r_relock_cnt <= r_relock_cnt + 1'b1;
    end
  end

  assign phaser_rst_o    = r_phaser_rst;
  assign phaser_pwrdwn_o = r_phaser_pwrdwn;
  assign phy_rst_o       = r_phy_rst;
  assign ready_o         = r_ready;
  assign lock_lost_o     = r_lock_lost;
  assign timeout_o       = r_timeout;
  assign relock_cnt_o    = r_relock_cnt;
  assign state_o         = r_state;

endmodule

// File: tb/tb_phaser_lock_sequencer.sv
// Directed bench for phaser_lock_sequencer; inputs driven and outputs sampled on the falling edge.
module tb_phaser_lock_sequencer;

  localparam int unsigned CntW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            locked = 1'b0;
  logic            pwrdwn = 1'b0;
  logic            phaser_rst_o, phaser_pwrdwn_o, phy_rst_o, ready_o, lock_lost_o, timeout_o;
  logic [CntW-1:0] relock_cnt_o;
  logic [2:0]      state_o;

  int n_checks = 0;
  int n_fail   = 0;

  phaser_lock_sequencer #(
    .SYNC_STAGES     (2),
    .RST_PULSE_CYCLES(8),
    .STABLE_CYCLES   (64),
    .RELEASE_CYCLES  (16),
    .TIMEOUT_CYCLES  (64),
    .CNT_W           (CntW)
  ) dut (
    .delay_CLKIN    (clk),
    .delay_RST      (rst),
    .locked_i       (locked),
    .pwrdwn_i       (pwrdwn),
    .phaser_rst_o   (phaser_rst_o),
    .phaser_pwrdwn_o(phaser_pwrdwn_o),
    .phy_rst_o      (phy_rst_o),
    .ready_o        (ready_o),
    .lock_lost_o    (lock_lost_o),
    .timeout_o      (timeout_o),
    .relock_cnt_o   (relock_cnt_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves delay_RST released on a falling edge; that edge is cycle 0 for the caller.
  task automatic do_reset();
    rst = 1'b1; locked = 1'b0; pwrdwn = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step(1);
      if (ready_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; pwrdwn = 1'b0;
    step(2);
    n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rst_state got=%0d want=0", state_o); end
    n_checks++; if ({phaser_rst_o, phaser_pwrdwn_o, phy_rst_o, ready_o, lock_lost_o, timeout_o} !== 6'b101000)
      begin n_fail++; $display("FAIL rst_outputs got=%b want=101000",
        {phaser_rst_o, phaser_pwrdwn_o, phy_rst_o, ready_o, lock_lost_o, timeout_o}); end
    n_checks++; if (relock_cnt_o !== 2'd0) begin n_fail++; $display("FAIL rst_relock got=%0d want=0", relock_cnt_o); end
  endtask

  task automatic test_timeout();
    do_reset();
    step(7);
    n_checks++; if (state_o !== 3'd0 || phaser_rst_o !== 1'b1)
      begin n_fail++; $display("FAIL prst_hold state=%0d prst=%b want 0/1", state_o, phaser_rst_o); end
    step(1);
    n_checks++; if (state_o !== 3'd1 || phaser_rst_o !== 1'b0 || phy_rst_o !== 1'b1)
      begin n_fail++; $display("FAIL prst_exit state=%0d prst=%b phy=%b want 1/0/1", state_o, phaser_rst_o, phy_rst_o); end
    step(63);
    n_checks++; if (state_o !== 3'd1 || timeout_o !== 1'b0)
      begin n_fail++; $display("FAIL wait_pre_timeout state=%0d to=%b want 1/0", state_o, timeout_o); end
    step(1);
    n_checks++; if (state_o !== 3'd0 || timeout_o !== 1'b1 || phaser_rst_o !== 1'b1)
      begin n_fail++; $display("FAIL timeout_retry state=%0d to=%b prst=%b want 0/1/1", state_o, timeout_o, phaser_rst_o); end
    step(8);
    n_checks++; if (state_o !== 3'd1 || timeout_o !== 1'b1 || phaser_rst_o !== 1'b0)
      begin n_fail++; $display("FAIL timeout_sticky state=%0d to=%b prst=%b want 1/1/0", state_o, timeout_o, phaser_rst_o); end
  endtask

  task automatic test_lock_latency();
    do_reset();
    step(20);
    locked = 1'b1;
    step(2);
    n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL sync_latency state=%0d want=1", state_o); end
    step(1);
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL enter_stable state=%0d want=2", state_o); end
    step(64);
    n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL enter_release state=%0d want=3", state_o); end
    step(15);
    n_checks++; if (ready_o !== 1'b0 || phy_rst_o !== 1'b1)
      begin n_fail++; $display("FAIL ready_early ready=%b phy=%b want 0/1", ready_o, phy_rst_o); end
    step(1);
    n_checks++; if (ready_o !== 1'b1 || phy_rst_o !== 1'b0 || state_o !== 3'd4)
      begin n_fail++; $display("FAIL ready_83 ready=%b phy=%b state=%0d want 1/0/4", ready_o, phy_rst_o, state_o); end
  endtask

  task automatic test_stable_glitch();
    do_reset();
    step(20);
    locked = 1'b1;
    step(33);
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL glitch_pre state=%0d want=2", state_o); end
    locked = 1'b0;
    step(3);
    n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL glitch_drop state=%0d want=1", state_o); end
    step(2);
    locked = 1'b1;
    step(2);
    n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL glitch_wait state=%0d want=1", state_o); end
    step(1);
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL glitch_restable state=%0d want=2", state_o); end
    step(79);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL glitch_ready_early ready=%b want=0", ready_o); end
    step(1);
    n_checks++; if (ready_o !== 1'b1 || relock_cnt_o !== 2'd0)
      begin n_fail++; $display("FAIL glitch_ready ready=%b relock=%0d want 1/0", ready_o, relock_cnt_o); end
  endtask

  task automatic test_lock_loss();
    bit ok;
    logic [CntW-1:0] exp_cnt;
    do_reset();
    locked = 1'b1;
    wait_ready(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL loss_first_ready got=timeout want=ready"); end
    locked = 1'b0;
    step(2);
    n_checks++; if (lock_lost_o !== 1'b0 || ready_o !== 1'b1)
      begin n_fail++; $display("FAIL loss_sync lost=%b ready=%b want 0/1", lock_lost_o, ready_o); end
    step(1);
    n_checks++; if (lock_lost_o !== 1'b1 || ready_o !== 1'b0 || phy_rst_o !== 1'b1 || relock_cnt_o !== 2'd1 || state_o !== 3'd1)
      begin n_fail++; $display("FAIL loss_edge lost=%b ready=%b phy=%b cnt=%0d state=%0d want 1/0/1/1/1",
        lock_lost_o, ready_o, phy_rst_o, relock_cnt_o, state_o); end
    step(1);
    n_checks++; if (lock_lost_o !== 1'b0 || relock_cnt_o !== 2'd1)
      begin n_fail++; $display("FAIL loss_pulse_width lost=%b cnt=%0d want 0/1", lock_lost_o, relock_cnt_o); end
    for (int k = 2; k <= 5; k++) begin
      locked = 1'b1;
      wait_ready(300, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL loss_ready_%0d got=timeout want=ready", k); end
      locked = 1'b0;
      step(3);
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      n_checks++; if (relock_cnt_o !== exp_cnt || lock_lost_o !== 1'b1)
        begin n_fail++; $display("FAIL loss_count_%0d cnt=%0d lost=%b want %0d/1", k, relock_cnt_o, lock_lost_o, exp_cnt); end
    end
    // Hold lock low long enough to expire WAIT_LOCK once.
    step(70);
    n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL loss_timeout to=%b want=1", timeout_o); end
    locked = 1'b1;
    wait_ready(300, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL loss_final_ready got=timeout want=ready"); end
  endtask

  task automatic test_async_reset();
    n_checks++; if (relock_cnt_o !== 2'd3 || timeout_o !== 1'b1 || ready_o !== 1'b1)
      begin n_fail++; $display("FAIL async_pre cnt=%0d to=%b ready=%b want 3/1/1", relock_cnt_o, timeout_o, ready_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({phaser_rst_o, phaser_pwrdwn_o, phy_rst_o, ready_o, lock_lost_o, timeout_o} !== 6'b101000)
      begin n_fail++; $display("FAIL async_outputs got=%b want=101000",
        {phaser_rst_o, phaser_pwrdwn_o, phy_rst_o, ready_o, lock_lost_o, timeout_o}); end
    n_checks++; if (relock_cnt_o !== 2'd0 || state_o !== 3'd0)
      begin n_fail++; $display("FAIL async_state cnt=%0d state=%0d want 0/0", relock_cnt_o, state_o); end
  endtask

  task automatic test_pwrdwn();
    do_reset();
    step(20);
    locked = 1'b1;
    step(67);
    n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL pd_pre state=%0d want=3", state_o); end
    step(3);
    pwrdwn = 1'b1;
    step(1);
    n_checks++; if (state_o !== 3'd5 || phaser_pwrdwn_o !== 1'b1 || phaser_rst_o !== 1'b1 || phy_rst_o !== 1'b1 || ready_o !== 1'b0)
      begin n_fail++; $display("FAIL pd_enter state=%0d pd=%b prst=%b phy=%b ready=%b want 5/1/1/1/0",
        state_o, phaser_pwrdwn_o, phaser_rst_o, phy_rst_o, ready_o); end
    step(4);
    pwrdwn = 1'b0;
    step(1);
    n_checks++; if (state_o !== 3'd0 || phaser_pwrdwn_o !== 1'b0 || phaser_rst_o !== 1'b1)
      begin n_fail++; $display("FAIL pd_exit state=%0d pd=%b prst=%b want 0/0/1", state_o, phaser_pwrdwn_o, phaser_rst_o); end
    step(8);
    n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL pd_wait state=%0d want=1", state_o); end
    step(1);
    n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL pd_stable state=%0d want=2", state_o); end
    step(79);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL pd_ready_early ready=%b want=0", ready_o); end
    step(1);
    n_checks++; if (ready_o !== 1'b1 || phy_rst_o !== 1'b0)
      begin n_fail++; $display("FAIL pd_ready ready=%b phy=%b want 1/0", ready_o, phy_rst_o); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock_latency();
    test_stable_glitch();
    test_lock_loss();
    test_async_reset();
    test_pwrdwn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
